// File: rtl/ctrl_sequencer_if.sv
// Sequencer-to-datapath bundle: instruction/memory status inward,
// register enables, bus strobes and ALU operation outward.
interface ctrl_sequencer_if #(
  parameter int NREG = 16,
  parameter int OPW  = 5
);
  logic [31:0]     IR;
  logic            MemReady;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;
  logic            PCout;
  logic            PCin;
  logic            MARin;
  logic            MDRin;
  logic            MDRout;
  logic            IRin;
  logic            Yin;
  logic            Zin;
  logic            ZLOout;
  logic            ZHIout;
  logic            HIin;
  logic            LOin;
  logic            Read;
  logic            IncPC;
  logic [OPW-1:0]  AluOp;

  modport master (
    input  IR, MemReady,
    output Rin, Rout, PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin,
           ZLOout, ZHIout, HIin, LOin, Read, IncPC, AluOp
  );

  modport slave (
    output IR, MemReady,
    input  Rin, Rout, PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin,
           ZLOout, ZHIout, HIin, LOin, Read, IncPC, AluOp
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/decode/execute control sequencer with bounded memory wait,
// sticky timeout fault, HALT handling and a completed-fetch counter.
module ctrl_sequencer #(
  parameter int NREG     = 16,
  parameter int OPW      = 5,
  parameter int WAIT_MAX = 15
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Run,
  ctrl_sequencer_if.master       bus,
  output logic                   Done,
  output logic                   Fault,
  output logic [15:0]            InstrCount,
  output logic [3:0]             State
);

  localparam int RAW = $clog2(NREG);
  localparam int WCW = $clog2(WAIT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7
  } state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic [OPW-1:0] opcode;
  logic [RAW-1:0] ra, rb, rc;
  logic           is_alu, is_muldiv, is_halt, wait_expired;
  logic           unused_ir_bits;

  // Indices that do not name an existing register select nothing.
  function automatic logic [NREG-1:0] reg_sel(input logic [RAW-1:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++)
      if (idx == RAW'(i)) v[i] = 1'b1;
    return v;
  endfunction

  assign opcode         = bus.IR[31 -: OPW];
  assign ra             = bus.IR[31-OPW -: RAW];
  assign rb             = bus.IR[31-OPW-RAW -: RAW];
  assign rc             = bus.IR[31-OPW-2*RAW -: RAW];
  assign unused_ir_bits = ^bus.IR[31-OPW-3*RAW:0];

  assign is_alu       = (opcode <= OPW'(14));
  assign is_muldiv    = (opcode == OPW'(15)) || (opcode == OPW'(16));
  assign is_halt      = &opcode;
  assign wait_expired = (wait_cnt == WCW'(WAIT_MAX));

  assign State = state;

  always_ff @(posedge Clock) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (Run) state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1: begin
        // A late MemReady on the final allowed cycle still completes the fetch.
        if (bus.MemReady)      state_nxt = S_T2;
        else if (wait_expired) state_nxt = S_IDLE;
      end
      S_T2:   state_nxt = S_T3;
      S_T3: begin
        if (is_alu || is_muldiv) state_nxt = S_T4;
        else if (is_halt)        state_nxt = S_IDLE;
        else                     state_nxt = S_T0;
      end
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = is_muldiv ? S_T6 : S_T0;
      S_T6:   state_nxt = S_T0;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.Rin    = '0;
    bus.Rout   = '0;
    bus.PCout  = 1'b0;
    bus.PCin   = 1'b0;
    bus.MARin  = 1'b0;
    bus.MDRin  = 1'b0;
    bus.MDRout = 1'b0;
    bus.IRin   = 1'b0;
    bus.Yin    = 1'b0;
    bus.Zin    = 1'b0;
    bus.ZLOout = 1'b0;
    bus.ZHIout = 1'b0;
    bus.HIin   = 1'b0;
    bus.LOin   = 1'b0;
    bus.Read   = 1'b0;
    bus.IncPC  = 1'b0;
    bus.AluOp  = '0;
    case (state)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        bus.ZLOout = 1'b1;
        bus.PCin   = 1'b1;
        bus.Read   = 1'b1;
        bus.MDRin  = bus.MemReady;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        if (is_alu) begin
          bus.Rout = reg_sel(rb);
          bus.Yin  = 1'b1;
        end else if (is_muldiv) begin
          bus.Rout = reg_sel(ra);
          bus.Yin  = 1'b1;
        end
      end
      S_T4: begin
        bus.Rout  = is_muldiv ? reg_sel(rb) : reg_sel(rc);
        bus.Zin   = 1'b1;
        bus.AluOp = opcode;
      end
      S_T5: begin
        bus.ZLOout = 1'b1;
        if (is_muldiv) bus.LOin = 1'b1;
        else           bus.Rin  = reg_sel(ra);
      end
      S_T6: begin
        bus.ZHIout = 1'b1;
        bus.HIin   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      wait_cnt   <= '0;
      InstrCount <= '0;
      Done       <= 1'b0;
      Fault      <= 1'b0;
    end else begin
      if (state != S_T1)
        wait_cnt <= '0;
      else if (!bus.MemReady && !wait_expired)
        wait_cnt <= wait_cnt + WCW'(1);

      if (state == S_T2)
        InstrCount <= InstrCount + 16'd1;

      if (state == S_IDLE && Run)
        Done <= 1'b0;
      else if (state == S_T3 && is_halt)
        Done <= 1'b1;
      else if (state == S_T1 && !bus.MemReady && wait_expired)
        Done <= 1'b0;

      if (state == S_T1 && !bus.MemReady && wait_expired)
        Fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: fetch/execute sequences, memory wait,
// timeout fault, HALT, skipped opcode and mid-instruction reset.
module tb_ctrl_sequencer;

  localparam int NREG     = 16;
  localparam int OPW      = 5;
  localparam int WAIT_MAX = 15;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Run;
  logic        Done;
  logic        Fault;
  logic [15:0] InstrCount;
  logic [3:0]  State;
  int          total = 0;
  int          bad   = 0;

  ctrl_sequencer_if #(.NREG(NREG), .OPW(OPW)) bus();

  ctrl_sequencer #(.NREG(NREG), .OPW(OPW), .WAIT_MAX(WAIT_MAX)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Run        (Run),
    .bus        (bus),
    .Done       (Done),
    .Fault      (Fault),
    .InstrCount (InstrCount),
    .State      (State)
  );

  always #5 Clock = ~Clock;

  // Order: PCout PCin MARin MDRin | MDRout IRin Yin Zin | ZLOout ZHIout HIin LOin | Read IncPC
  function automatic logic [13:0] strobes();
    return {bus.PCout, bus.PCin, bus.MARin, bus.MDRin, bus.MDRout, bus.IRin,
            bus.Yin, bus.Zin, bus.ZLOout, bus.ZHIout, bus.HIin, bus.LOin,
            bus.Read, bus.IncPC};
  endfunction

  localparam logic [13:0] ST_NONE  = 14'b0000_0000_0000_00;
  localparam logic [13:0] ST_T0    = 14'b1010_0001_0000_01;
  localparam logic [13:0] ST_T1_RD = 14'b0101_0000_1000_10;
  localparam logic [13:0] ST_T1_WT = 14'b0100_0000_1000_10;
  localparam logic [13:0] ST_T2    = 14'b0000_1100_0000_00;
  localparam logic [13:0] ST_T3    = 14'b0000_0010_0000_00;
  localparam logic [13:0] ST_T4    = 14'b0000_0001_0000_00;
  localparam logic [13:0] ST_T5A   = 14'b0000_0000_1000_00;
  localparam logic [13:0] ST_T5M   = 14'b0000_0000_1001_00;
  localparam logic [13:0] ST_T6    = 14'b0000_0000_0110_00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; checks run 1 time unit after the rising edge.
  task automatic tick();
    logic [4:0] drivers;
    @(posedge Clock);
    #1;
    drivers = {bus.PCout, bus.MDRout, bus.ZLOout, bus.ZHIout, |bus.Rout};
    chk("bus_exclusive", {31'd0, ($countones(drivers) <= 1) && $onehot0(bus.Rout)}, 32'd1);
  endtask

  initial begin
    Reset_n      = 1'b0;
    Run          = 1'b0;
    bus.IR       = 32'h0;
    bus.MemReady = 1'b0;
    tick();
    tick();
    Reset_n = 1'b1;
    tick();
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_count", 32'(InstrCount), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_fault", 32'(Fault), 32'd0);
    chk("rst_strobes", 32'(strobes()), 32'(ST_NONE));
    chk("rst_rin_rout", {bus.Rin, bus.Rout}, 32'd0);
    chk("rst_aluop", 32'(bus.AluOp), 32'd0);

    // AND R1,R2,R3 with memory ready immediately
    bus.IR       = 32'h4891_8000;
    bus.MemReady = 1'b1;
    Run          = 1'b1;
    tick();
    Run = 1'b0;
    chk("and_t0_state", 32'(State), 32'd1);
    chk("and_t0_strobes", 32'(strobes()), 32'(ST_T0));
    tick();
    chk("and_t1_state", 32'(State), 32'd2);
    chk("and_t1_strobes", 32'(strobes()), 32'(ST_T1_RD));
    tick();
    chk("and_t2_strobes", 32'(strobes()), 32'(ST_T2));
    tick();
    chk("and_t3_state", 32'(State), 32'd4);
    chk("and_t3_rout", 32'(bus.Rout), 32'h0004);
    chk("and_t3_strobes", 32'(strobes()), 32'(ST_T3));
    chk("and_count", 32'(InstrCount), 32'd1);
    tick();
    chk("and_t4_rout", 32'(bus.Rout), 32'h0008);
    chk("and_t4_aluop", 32'(bus.AluOp), 32'd9);
    chk("and_t4_strobes", 32'(strobes()), 32'(ST_T4));
    tick();
    chk("and_t5_rin", 32'(bus.Rin), 32'h0002);
    chk("and_t5_rout", 32'(bus.Rout), 32'h0000);
    chk("and_t5_strobes", 32'(strobes()), 32'(ST_T5A));
    tick();
    chk("and_next_t0", 32'(State), 32'd1);

    // Same instruction again, memory holds off for three cycles
    bus.MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_t1_state", 32'(State), 32'd2);
      chk("wait_t1_strobes", 32'(strobes()), 32'(ST_T1_WT));
    end
    tick();
    bus.MemReady = 1'b1;
    #1;
    chk("wait_last_state", 32'(State), 32'd2);
    chk("wait_last_strobes", 32'(strobes()), 32'(ST_T1_RD));
    tick();
    chk("wait_t2_state", 32'(State), 32'd3);
    chk("wait_no_fault", 32'(Fault), 32'd0);
    tick();
    tick();
    tick();
    tick();
    chk("wait_done_t0", 32'(State), 32'd1);
    chk("wait_count", 32'(InstrCount), 32'd2);

    // MUL Ra=4 Rb=5
    bus.IR = 32'h7A28_0000;
    tick();
    tick();
    tick();
    chk("mul_t3_rout", 32'(bus.Rout), 32'h0010);
    chk("mul_t3_strobes", 32'(strobes()), 32'(ST_T3));
    tick();
    chk("mul_t4_rout", 32'(bus.Rout), 32'h0020);
    chk("mul_t4_aluop", 32'(bus.AluOp), 32'd15);
    tick();
    chk("mul_t5_strobes", 32'(strobes()), 32'(ST_T5M));
    chk("mul_t5_rin", 32'(bus.Rin), 32'h0000);
    tick();
    chk("mul_t6_state", 32'(State), 32'd7);
    chk("mul_t6_strobes", 32'(strobes()), 32'(ST_T6));
    tick();
    chk("mul_then_t0", 32'(State), 32'd1);

    // HALT
    bus.IR = 32'hF800_0000;
    tick();
    tick();
    tick();
    chk("halt_t3_state", 32'(State), 32'd4);
    chk("halt_t3_strobes", 32'(strobes()), 32'(ST_NONE));
    chk("halt_t3_rout", 32'(bus.Rout), 32'h0000);
    tick();
    chk("halt_idle", 32'(State), 32'd0);
    chk("halt_done", 32'(Done), 32'd1);
    chk("halt_count", 32'(InstrCount), 32'd4);
    tick();
    chk("halt_stays", 32'(State), 32'd0);
    chk("halt_done_held", 32'(Done), 32'd1);
    Run = 1'b1;
    tick();
    Run = 1'b0;
    chk("halt_restart_t0", 32'(State), 32'd1);
    chk("halt_done_clr", 32'(Done), 32'd0);

    // Undefined opcode 20 is fetched, counted and skipped
    bus.IR = 32'hA000_0000;
    tick();
    tick();
    tick();
    chk("skip_t3_strobes", 32'(strobes()), 32'(ST_NONE));
    tick();
    chk("skip_t0", 32'(State), 32'd1);
    chk("skip_count", 32'(InstrCount), 32'd5);

    // Reset in the middle of T4
    bus.IR = 32'h4891_8000;
    tick();
    tick();
    tick();
    tick();
    chk("rst4_pre_state", 32'(State), 32'd5);
    chk("rst4_pre_aluop", 32'(bus.AluOp), 32'd9);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    chk("rst4_state", 32'(State), 32'd0);
    chk("rst4_aluop", 32'(bus.AluOp), 32'd0);
    chk("rst4_strobes", 32'(strobes()), 32'(ST_NONE));
    chk("rst4_count", 32'(InstrCount), 32'd0);

    // Memory never answers: timeout after WAIT_MAX counted wait cycles
    bus.MemReady = 1'b0;
    Run          = 1'b1;
    tick();
    Run = 1'b0;
    tick();
    chk("to_t1", 32'(State), 32'd2);
    for (int i = 0; i < WAIT_MAX; i++) tick();
    chk("to_still_t1", 32'(State), 32'd2);
    chk("to_no_fault_yet", 32'(Fault), 32'd0);
    tick();
    chk("to_idle", 32'(State), 32'd0);
    chk("to_fault", 32'(Fault), 32'd1);
    chk("to_done", 32'(Done), 32'd0);
    chk("to_strobes", 32'(strobes()), 32'(ST_NONE));

    // Restart after fault; MemReady arriving on the last allowed cycle wins
    Run = 1'b1;
    tick();
    Run = 1'b0;
    chk("fault_restart_t0", 32'(State), 32'd1);
    chk("fault_sticky", 32'(Fault), 32'd1);
    tick();
    for (int i = 0; i < WAIT_MAX; i++) tick();
    bus.MemReady = 1'b1;
    tick();
    chk("late_ready_t2", 32'(State), 32'd3);
    chk("late_ready_fault", 32'(Fault), 32'd1);

    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    chk("fault_rst_clr", 32'(Fault), 32'd0);
    chk("fault_rst_state", 32'(State), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 Parameter NREG, default 16: number of general registers; register field width RAW = log2(NREG).
REQ-002 Parameter OPW, default 5: opcode width; opcode occupies IR[31:32-OPW].
REQ-003 Parameter WAIT_MAX, default 15: maximum memory-wait cycles before fault.
REQ-004 Clock  in  1  single clock; all state changes on rising edge.
REQ-005 Reset_n  in  1  synchronous, active-low reset.
REQ-006 Run  in  1  start request; sampled only in IDLE.
REQ-007 IR  in  32  instruction register contents: Ra=IR[31-OPW -: RAW], Rb next RAW bits, Rc next RAW bits.
REQ-008 MemReady  in  1  memory read data valid.
REQ-009 Rin, Rout  out  NREG each  one-hot register load / bus-drive enables.
REQ-010 PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, ZLOout, ZHIout, HIin, LOin, Read, IncPC  out  1 each  datapath strobes.
REQ-011 AluOp  out  OPW  ALU operation; equals IR opcode in T4, else 0.
REQ-012 Done  out  1  high while in IDLE after HALT; Fault  out  1  sticky memory-timeout flag.
REQ-013 InstrCount  out  16  completed-fetch counter; State  out  4  current state code.

Function
REQ-014 States, codes: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7; state register is the only state-holding element except the wait counter, InstrCount, Done and Fault.
REQ-015 IDLE: all strobes 0; Run=1 -> T0 next cycle, clears Done; Run ignored in every other state.
REQ-016 T0: PCout, MARin, IncPC, Zin = 1; -> T1.
REQ-017 T1: ZLOout, PCin, Read = 1 every T1 cycle; MDRin = MemReady (combinational); MemReady=1 -> T2, else stay T1 and increment wait counter.
REQ-018 Wait counter clears on T1 entry; reaching WAIT_MAX with MemReady=0 -> IDLE, Fault=1, Done=0; MemReady=1 in the same cycle as WAIT_MAX wins (-> T2, no fault).
REQ-019 T2: MDRout, IRin = 1; InstrCount increments (wraps 0xFFFF->0x0000); -> T3.
REQ-020 Decode in T3 uses IR as loaded in T2.
REQ-021 ALU class (opcode 0..14): T3 Rout[Rb], Yin; T4 Rout[Rc], Zin, AluOp=opcode; T5 ZLOout, Rin[Ra]; -> T0.
REQ-022 MUL/DIV (opcode 15, 16): T3 Rout[Ra], Yin; T4 Rout[Rb], Zin, AluOp=opcode; T5 ZLOout, LOin; T6 ZHIout, HIin; -> T0.
REQ-023 HALT (all-ones opcode): T3 no strobes, Done=1 -> IDLE.
REQ-024 Any other opcode: T3 no strobes -> T0 (instruction skipped, counted).
REQ-025 At most one Rout bit and one bus-driving strobe (PCout, MDRout, ZLOout, ZHIout, Rout) high per cycle.
REQ-026 Register index >= NREG (non-power-of-two NREG): enable vector all zero for that field.

Reset
REQ-027 Reset_n=0 at a rising edge: State=IDLE, InstrCount=0, Done=0, Fault=0, wait counter=0, every strobe, Rin, Rout, AluOp = 0 from next cycle; applies mid-instruction and mid-wait.
REQ-028 Fault clears only by reset; Run after fault restarts at T0 with Fault still 1.

Verification
REQ-029 Reset, Run=1, IR=0x48918000 (AND R1,R2,R3), MemReady=1 in T1 -> T3 Rout=0x0004, Yin; T4 Rout=0x0008, AluOp=9, Zin; T5 Rin=0x0002, ZLOout; InstrCount=1.
REQ-030 MemReady held 0 for 3 cycles then 1 -> T1 lasts 4 cycles, Read=1 throughout, MDRin=1 only in last, no fault.
REQ-031 MemReady never asserted -> after WAIT_MAX cycles State=0, Fault=1, all strobes 0.
REQ-032 IR opcode 15, Ra=4, Rb=5 -> T3 Rout=0x0010, T4 Rout=0x0020, T5 LOin, T6 HIin, then T0.
REQ-033 IR=0xF8000000 -> T3 then IDLE, Done=1; subsequent Run=1 -> T0, Done=0.
REQ-034 Reset_n=0 during T4 -> next cycle State=0, AluOp=0, Zin=0, InstrCount=0.
